// File: rtl/apb_reg_completer_if.sv
// rtl/apb_reg_completer_if.sv - APB bus bundle between requester and register completer
interface apb_reg_completer_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_reg_completer.sv
// rtl/apb_reg_completer.sv - APB completer with 15 R/W registers and a read-only ID register
// Optional error response: define APB_REG_COMPLETER_SLVERR_EN to drive pslverr.
module apb_reg_completer #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
  input  logic                clk,
  input  logic                rst,
  apb_reg_completer_if.slave  apb,
  output logic                wr_pulse,
  output logic [3:0]          wr_index
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_addr;
  logic        r_write;
  logic [31:0] r_wdata;
  logic [2:0]  r_cnt;
  logic [31:0] r_regs [15];
  logic [31:0] r_prdata;
  logic        r_wr_pulse;
  logic [3:0]  r_wr_index;

  logic [3:0]  w_idx;
  logic        w_bad_addr;
  logic        w_is_id;
  logic        w_pready;
  logic        w_commit;
  logic [31:0] w_rd_val;

  assign w_idx      = r_addr[5:2];
  assign w_bad_addr = (r_addr[1:0] != 2'b00) || (r_addr[7:6] != 2'b00);
  assign w_is_id    = (w_idx == 4'd15);
  assign w_pready   = (r_state == ACCESS) && (r_cnt == 3'd0) && apb.psel && apb.penable;
  assign w_commit   = w_pready && r_write && !w_bad_addr && !w_is_id;
  assign w_rd_val   = w_bad_addr ? 32'h0 : (w_is_id ? ID_VALUE : r_regs[w_idx]);

  assign apb.pready = w_pready;
  assign apb.prdata = r_prdata;
  assign wr_pulse   = r_wr_pulse;
  assign wr_index   = r_wr_index;

`ifdef APB_REG_COMPLETER_SLVERR_EN
  assign apb.pslverr = w_pready && (w_bad_addr || (r_write && w_is_id));
`else
  assign apb.pslverr = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (apb.psel && !apb.penable) w_state_next = SETUP;
      SETUP:   w_state_next = ACCESS;
      // Completion and abort both return to IDLE; a new transfer never starts from ACCESS.
      ACCESS:  if (w_pready || !apb.psel || !apb.penable) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_addr     <= 8'h0;
      r_write    <= 1'b0;
      r_wdata    <= 32'h0;
      r_cnt      <= 3'd0;
      r_prdata   <= 32'h0;
      r_wr_pulse <= 1'b0;
      r_wr_index <= 4'h0;
      for (int i = 0; i < 15; i++) r_regs[i] <= 32'h0;
    end else begin
      r_state    <= w_state_next;
      r_wr_pulse <= w_commit;
      if (w_commit) begin
        r_regs[w_idx] <= r_wdata;
        r_wr_index    <= w_idx;
      end
      if (r_state == IDLE && w_state_next == SETUP) begin
        r_addr  <= apb.paddr;
        r_write <= apb.pwrite;
        r_wdata <= apb.pwdata;
        r_cnt   <= 3'(WAIT_STATES);
      end else if (r_state == ACCESS && r_cnt != 3'd0) begin
        r_cnt <= r_cnt - 3'd1;
      end
      // Read data is only presented during ACCESS; it is loaded once on entry.
      if (w_state_next != ACCESS) r_prdata <= 32'h0;
      else if (r_state == SETUP)  r_prdata <= w_rd_val;
    end
  end

endmodule

// File: tb/tb_apb_reg_completer.sv
// tb/tb_apb_reg_completer.sv - directed bench for apb_reg_completer at WAIT_STATES 0, 1 and 3
module tb_apb_reg_completer;

  localparam logic [31:0] ID = 32'hA5B0_0001;
`ifdef APB_REG_COMPLETER_SLVERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        b_psel, b_penable, b_pwrite;
  logic [7:0]  b_paddr;
  logic [31:0] b_pwdata;
  int          sel;

  logic [31:0] o_prdata;
  logic        o_pready, o_pslverr, o_wr_pulse;
  logic [3:0]  o_wr_index;

  logic        wp0, wp1, wp3;
  logic [3:0]  wi0, wi1, wi3;

  int          n_pass;
  int          n_total;
  int          pulse_cnt;
  logic [3:0]  pulse_idx[$];

  apb_reg_completer_if if0 ();
  apb_reg_completer_if if1 ();
  apb_reg_completer_if if3 ();

  assign if0.psel = b_psel && (sel == 0);
  assign if1.psel = b_psel && (sel == 1);
  assign if3.psel = b_psel && (sel == 3);
  assign {if0.penable, if0.pwrite, if0.paddr, if0.pwdata} = {b_penable, b_pwrite, b_paddr, b_pwdata};
  assign {if1.penable, if1.pwrite, if1.paddr, if1.pwdata} = {b_penable, b_pwrite, b_paddr, b_pwdata};
  assign {if3.penable, if3.pwrite, if3.paddr, if3.pwdata} = {b_penable, b_pwrite, b_paddr, b_pwdata};

  apb_reg_completer #(.WAIT_STATES(0), .ID_VALUE(ID)) dut0 (.clk(clk), .rst(rst), .apb(if0), .wr_pulse(wp0), .wr_index(wi0));
  apb_reg_completer #(.WAIT_STATES(1), .ID_VALUE(ID)) dut1 (.clk(clk), .rst(rst), .apb(if1), .wr_pulse(wp1), .wr_index(wi1));
  apb_reg_completer #(.WAIT_STATES(3), .ID_VALUE(ID)) dut3 (.clk(clk), .rst(rst), .apb(if3), .wr_pulse(wp3), .wr_index(wi3));

  always_comb begin
    o_prdata   = if1.prdata;
    o_pready   = if1.pready;
    o_pslverr  = if1.pslverr;
    o_wr_pulse = wp1;
    o_wr_index = wi1;
    if (sel == 0) begin
      o_prdata = if0.prdata; o_pready = if0.pready; o_pslverr = if0.pslverr;
      o_wr_pulse = wp0; o_wr_index = wi0;
    end else if (sel == 3) begin
      o_prdata = if3.prdata; o_pready = if3.pready; o_pslverr = if3.pslverr;
      o_wr_pulse = wp3; o_wr_index = wi3;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && o_wr_pulse) begin
      pulse_cnt++;
      pulse_idx.push_back(o_wr_index);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          output logic [31:0] rd, output logic err, output int acc);
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = wr; b_paddr = addr; b_pwdata = data;
    @(posedge clk); #1;
    b_penable = 1'b1;
    @(posedge clk); #1;
    acc = 1;
    while (!o_pready && acc < 16) begin
      @(posedge clk); #1;
      acc++;
    end
    check("pready_seen", 32'(o_pready), 32'h1);
    rd  = o_prdata;
    err = o_pslverr;
    @(posedge clk); #1;
  endtask

  task automatic apb_idle();
    b_psel = 1'b0; b_penable = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        err;
  int          acc;
  int          p0;

  initial begin
    n_pass = 0; n_total = 0; pulse_cnt = 0;
    rst = 1'b0; sel = 1;
    b_psel = 1'b0; b_penable = 1'b0; b_pwrite = 1'b0; b_paddr = 8'h0; b_pwdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prdata", o_prdata, 32'h0);
    check("rst_pready", 32'(o_pready), 32'h0);
    check("rst_pslverr", 32'(o_pslverr), 32'h0);
    check("rst_wr_pulse", 32'(o_wr_pulse), 32'h0);
    check("rst_wr_index", 32'(o_wr_index), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    // WAIT_STATES=1: write then read register 2
    sel = 1;
    apb_xfer(1'b1, 8'h08, 32'h1234_5678, rd, err, acc);
    check("ws1_wr_acc", 32'(acc), 32'd2);
    check("ws1_wr_pulse", 32'(o_wr_pulse), 32'h1);
    check("ws1_wr_index", 32'(o_wr_index), 32'h2);
    apb_idle();
    check("ws1_pulse_one_cycle", 32'(o_wr_pulse), 32'h0);
    apb_xfer(1'b0, 8'h08, 32'h0, rd, err, acc);
    check("ws1_rd_acc", 32'(acc), 32'd2);
    check("ws1_rd_data", rd, 32'h1234_5678);
    check("ws1_rd_err", 32'(err), 32'h0);
    apb_idle();
    check("ws1_pulse_count", 32'(pulse_cnt), 32'd1);

    // WAIT_STATES=0: ID register
    sel = 0;
    apb_xfer(1'b0, 8'h3C, 32'h0, rd, err, acc);
    check("ws0_rd_acc", 32'(acc), 32'd1);
    check("ws0_rd_id", rd, ID);
    check("ws0_rd_err", 32'(err), 32'h0);
    apb_idle();

    // error accesses: ID write, misaligned+out-of-range, out-of-range
    sel = 1;
    apb_xfer(1'b1, 8'h00, 32'h5555_AAAA, rd, err, acc);
    apb_idle();
    p0 = pulse_cnt;
    apb_xfer(1'b1, 8'h3C, 32'hFFFF_FFFF, rd, err, acc);
    check("err_wr_3c", 32'(err), 32'(EXP_ERR));
    apb_xfer(1'b1, 8'h41, 32'hBAD0_0041, rd, err, acc);
    check("err_wr_41", 32'(err), 32'(EXP_ERR));
    apb_xfer(1'b1, 8'h40, 32'hBAD0_0040, rd, err, acc);
    check("err_wr_40", 32'(err), 32'(EXP_ERR));
    apb_idle();
    check("err_no_pulse", 32'(pulse_cnt), 32'(p0));
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, acc);
    check("err_reg0_kept", rd, 32'h5555_AAAA);
    apb_xfer(1'b0, 8'h3C, 32'h0, rd, err, acc);
    check("err_id_kept", rd, ID);
    apb_xfer(1'b0, 8'h41, 32'h0, rd, err, acc);
    check("err_rd_41_data", rd, 32'h0);
    check("err_rd_41_err", 32'(err), 32'(EXP_ERR));
    apb_idle();

    // WAIT_STATES=3: abort a write to register 1 in ACCESS cycle 2
    sel = 3;
    apb_xfer(1'b1, 8'h04, 32'h1111_1111, rd, err, acc);
    check("ws3_wr_acc", 32'(acc), 32'd4);
    apb_idle();
    p0 = pulse_cnt;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 8'h04; b_pwdata = 32'h2222_2222;
    @(posedge clk); #1;
    b_penable = 1'b1;
    @(posedge clk); #1;
    check("abort_acc1_prdata", o_prdata, 32'h1111_1111);
    check("abort_acc1_pready", 32'(o_pready), 32'h0);
    @(posedge clk); #1;
    b_psel = 1'b0; b_penable = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_prdata", o_prdata, 32'h0);
    @(posedge clk); #1;
    check("abort_no_pulse", 32'(pulse_cnt), 32'(p0));
    apb_xfer(1'b0, 8'h04, 32'h0, rd, err, acc);
    check("abort_reg1_kept", rd, 32'h1111_1111);
    apb_idle();

    // back-to-back writes without an idle cycle
    sel = 1;
    p0 = pulse_cnt;
    pulse_idx.delete();
    apb_xfer(1'b1, 8'h00, 32'hA0A0_0000, rd, err, acc);
    apb_xfer(1'b1, 8'h04, 32'hB0B0_0001, rd, err, acc);
    apb_idle();
    check("b2b_pulse_count", 32'(pulse_cnt), 32'(p0 + 2));
    check("b2b_idx_size", 32'(pulse_idx.size()), 32'd2);
    if (pulse_idx.size() == 2) begin
      check("b2b_idx0", 32'(pulse_idx[0]), 32'h0);
      check("b2b_idx1", 32'(pulse_idx[1]), 32'h1);
    end
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, acc);
    check("b2b_reg0", rd, 32'hA0A0_0000);
    apb_xfer(1'b0, 8'h04, 32'h0, rd, err, acc);
    check("b2b_reg1", rd, 32'hB0B0_0001);
    apb_idle();

    // reset during ACCESS of a write to register 0
    p0 = pulse_cnt;
    b_psel = 1'b1; b_penable = 1'b0; b_pwrite = 1'b1; b_paddr = 8'h00; b_pwdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    b_penable = 1'b1;
    @(posedge clk); #1;
    check("rstacc_pready_before", 32'(o_pready), 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstacc_prdata", o_prdata, 32'h0);
    check("rstacc_pready", 32'(o_pready), 32'h0);
    check("rstacc_pslverr", 32'(o_pslverr), 32'h0);
    check("rstacc_wr_pulse", 32'(o_wr_pulse), 32'h0);
    check("rstacc_wr_index", 32'(o_wr_index), 32'h0);
    rst = 1'b1;
    b_psel = 1'b0; b_penable = 1'b0;
    @(posedge clk); #1;
    check("rstacc_no_pulse", 32'(pulse_cnt), 32'(p0));
    apb_xfer(1'b0, 8'h00, 32'h0, rd, err, acc);
    check("rstacc_reg0", rd, 32'h0);
    apb_xfer(1'b0, 8'h08, 32'h0, rd, err, acc);
    check("rstacc_reg2", rd, 32'h0);
    apb_xfer(1'b0, 8'h3C, 32'h0, rd, err, acc);
    check("rstacc_id", rd, ID);
    apb_idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/apb_reg_completer.md
APB_REG_COMPLETER -- requirements
Module: apb_reg_completer

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, giving access-phase wait cycles before PREADY (range 0..7).
REQ-002 SHALL have parameter ID_VALUE, default 32'hA5B0_0001, giving the read-only value of register 15.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-005 SHALL have port psel  input  1  completer select.
REQ-006 SHALL have port penable  input  1  access-phase indicator.
REQ-007 SHALL have port pwrite  input  1  1 = write, 0 = read.
REQ-008 SHALL have port paddr  input  8  byte address.
REQ-009 SHALL have port pwdata  input  32  write data.
REQ-010 SHALL have port prdata  output  32  read data.
REQ-011 SHALL have port pready  output  1  transfer completion.
REQ-012 SHALL have port pslverr  output  1  transfer error; valid only while pready=1.
REQ-013 SHALL have port wr_pulse  output  1  one-cycle strobe after each committed register write.
REQ-014 SHALL have port wr_index  output  4  index of the register written; valid with wr_pulse.

Function
REQ-015 SHALL contain 16 x 32-bit registers at byte addresses 0x00-0x3C, selected by paddr[5:2].
- Registers 0-14 are read/write.
- Register 15 is read-only and always returns ID_VALUE.
REQ-016 SHALL implement FSM states IDLE, SETUP and ACCESS.
- IDLE -> SETUP when psel=1 and penable=0.
- SETUP -> ACCESS unconditionally.
- ACCESS -> IDLE when pready=1, or on abort (REQ-021).
REQ-017 SHALL capture paddr, pwrite and pwdata in IDLE on the cycle that enters SETUP, and load the wait counter with WAIT_STATES at the same time.
REQ-018 SHALL assert pready combinationally when state=ACCESS, counter=0, psel=1 and penable=1.
- The counter decrements once per ACCESS cycle while it is nonzero.
- Result: pready rises in ACCESS cycle WAIT_STATES+1.
REQ-019 SHALL commit a write on the rising edge where pready=1, pwrite=1 and no error is flagged; wr_pulse=1 and wr_index=paddr[5:2] on the following cycle only.
REQ-020 SHALL register prdata on the SETUP -> ACCESS edge from the captured address.
- prdata holds that value through ACCESS.
- prdata is driven 32'h0 in all other states and on errored reads.
REQ-021 SHALL abort to IDLE with no register update and no wr_pulse if psel=0 or penable=0 during ACCESS before pready.
REQ-022 SHALL ignore penable=1 in IDLE, and SHALL NOT start a new transfer from ACCESS.
- Back-to-back transfers re-enter SETUP through IDLE.
REQ-023 SHALL treat paddr[1:0]!=0 as misaligned and paddr[7:6]!=0 as out-of-range; both SHALL suppress the write and return prdata=0.

Reset
REQ-024 SHALL, when rst=0 at a clock edge, return to IDLE and clear all of the following:
- registers 0-14 to 32'h0;
- the wait counter and captured fields;
- prdata to 32'h0, and pready, pslverr, wr_pulse, wr_index to 0.
REQ-025 SHALL abandon any transfer in progress on reset with no register update; register 15 remains ID_VALUE.

Configuration
REQ-026 SHALL honour macro APB_REG_COMPLETER_SLVERR_EN.
- Defined: pslverr=1 together with pready for misaligned or out-of-range accesses and for writes to register 15; otherwise 0.
- Undefined: pslverr is tied 0, and those accesses complete silently (write dropped, read returns 0).

Verification
REQ-027 SHALL cover: WAIT_STATES=1; write 0x1234_5678 to 0x08, then read 0x08 -> pready in 2nd ACCESS cycle, prdata=0x1234_5678, wr_pulse once with wr_index=2.
REQ-028 SHALL cover: WAIT_STATES=0; read 0x3C -> pready in 1st ACCESS cycle, prdata=ID_VALUE, pslverr=0.
REQ-029 SHALL cover: with macro defined, write to 0x3C, 0x41 and 0x40 -> pslverr=1 each time, register contents unchanged, no wr_pulse; with macro undefined -> pslverr=0, same unchanged contents.
REQ-030 SHALL cover: WAIT_STATES=3; drop psel in ACCESS cycle 2 of a write to 0x04 -> FSM to IDLE, register 1 unchanged, no wr_pulse.
REQ-031 SHALL cover: rst=0 during ACCESS of a write 0xDEAD_BEEF to 0x00 -> register 0 reads 0 afterwards, all outputs 0 on the cycle after reset.
REQ-032 SHALL cover: back-to-back writes to 0x00 and 0x04 with no idle cycle in between -> both committed, two wr_pulse strobes with wr_index 0 then 1.
